stream2di_multibuf: RTL and testbench
=====================================

# stream2di_multibuf

Synthesizable single-clock successor to the double-buffered stream-to-DI capture model. It packs pixel samples from the imager stream bus into DI-width words and captures whole frames into a ring of NUM_BUFS frame buffers. Committed frames are handed to the DI register read port in order. It sits between the imager pipeline output and the terminal's DI read path, and adds the following:
- counting of frames dropped when no buffer is free;
- sticky overflow on oversized frames;
- per-frame word count.

## Interface
Parameters:
- ADDR_WIDTH, default 10: log2 of words per frame buffer.
- DI_DATA_WIDTH, default 32: DI word width.
- STREAM_DATA_WIDTH, default 16: sample width. PPW = DI_DATA_WIDTH/STREAM_DATA_WIDTH must be 1, 2 or 4.
- NUM_BUFS, default 4: frame buffer count, a power of two ≥ 2.
- BUF_IDX_WIDTH, default 2: equals log2(NUM_BUFS).

Ports:
- clki  in  1  the only clock.
- resetb  in  1  asynchronous, active-low reset.
- enable  in  1  synchronous. When low, all state returns to reset values.
- dvi  in  1  stream data valid.
- dtypei  in  `DTYPE_WIDTH  stream data type.
- datai0, datai1, datai2  in  STREAM_DATA_WIDTH each  sample channels.
- mode  in  1  0: datai0 only. 1: three channels per pixel. Sampled only on FRAME_START.
- di_read_mode  in  1  high while the host reads a frame.
- di_read  in  1  advances the read pointer.
- di_read_rdy  out  1  high while the current frame has unread words.
- di_reg_datao  out  DI_DATA_WIDTH  current read word, combinational from the buffer and read address.
- frame_words  out  ADDR_WIDTH+1  word count of the oldest committed frame. 0 when no frame is committed.
- frames_dropped  out  16  saturating count of frames discarded for lack of a free buffer.
- overflow  out  1  sticky. Set when any frame exceeded 2^ADDR_WIDTH words.

## Operation
Storage and buffer ring:
- Storage is a register array of NUM_BUFS × 2^ADDR_WIDTH words. Up to 3 words may be written per cycle.
- The ring is managed by head (wr_idx), tail (rd_idx) and count (0..NUM_BUFS). Each buffer has a stored length len[i] of ADDR_WIDTH+1 bits.

Write FSM, states WIDLE, WCAPTURE, WDROP:
- WIDLE:
  - On dvi with FRAME_START and count<NUM_BUFS, latch mode, clear the packer and waddr, and go to WCAPTURE.
  - On dvi with FRAME_START and count==NUM_BUFS, go to WDROP and increment frames_dropped, saturating at 16'hFFFF.
- WCAPTURE, pixel beat (dvi and dtypei & `DTYPE_PIXEL_MASK nonzero):
  - Append samples to the packer LSB-first: datai0 in mode 0; datai0, datai1, datai2 in that order in mode 1.
  - Each time PPW samples are accumulated, write one word at waddr and increment waddr.
- WCAPTURE, FRAME_END:
  - Flush any partial word with its upper samples zero.
  - Set len[head] = words written, advance head and increment count.
  - Return to WIDLE.
- WCAPTURE, FRAME_START: abort the frame. Nothing is committed, waddr and the packer restart, and the FSM stays in WCAPTURE in the same buffer.
- WCAPTURE, frame larger than the buffer: words beyond address 2^ADDR_WIDTH−1 are discarded and overflow is set. The frame still commits with len = 2^ADDR_WIDTH.
- WDROP: ignore everything until FRAME_END, then go to WIDLE.

Read FSM, states RIDLE, RREAD:
- RIDLE: when di_read_mode=1 and count>0, latch rbuf=tail, clear raddr and go to RREAD.
- RREAD:
  - di_read_rdy = (raddr < len[rbuf]).
  - di_read while di_read_rdy is high increments raddr. di_read while di_read_rdy is low is ignored.
  - When di_read_mode falls, release the buffer (advance tail, decrement count) and return to RIDLE.
- di_reg_datao is the word at buffer[rbuf][raddr] in RREAD while di_read_rdy is high, and 0 otherwise.
- Commit and release in the same cycle: both pointers advance and count is unchanged.
- A buffer being read is never written, because count covers it until release.

## Timing
- Reset values (resetb low, or enable low at an edge):
  - both FSMs idle;
  - head, tail, count, waddr and raddr all 0;
  - di_read_rdy, frames_dropped, overflow and frame_words all 0.
- Capture latency: FRAME_END at edge N makes the frame committed after edge N. count and frame_words update from edge N.
- Read start: di_read_mode=1 sampled at edge M with count>0 gives di_read_rdy=1 after edge M, with word 0 on di_reg_datao in the same cycle.
- Each accepted di_read presents the next word one cycle later.
- After the last word is read, di_read_rdy drops on the same edge as the final increment.
- A frame with len=0 never asserts di_read_rdy, but is still released when di_read_mode falls.
- Throughput: one pixel per clock in both modes, with no backpressure on the stream side.

## Test plan
- PPW=2, mode 0, pixels 0x0001..0x0005 between FRAME_START and FRAME_END:
  - frame_words=3;
  - reads return 0x00020001, 0x00040003, 0x00000005;
  - di_read_rdy falls after the 3rd read.
- PPW=2, mode 1, two pixels (1,2,3) and (4,5,6): words read are 0x00020001, 0x00040003, 0x00060005.
- NUM_BUFS=4, five frames with no reads:
  - count=4 and frames_dropped=1;
  - reading returns frames 1–4 in order.
- ADDR_WIDTH=2, PPW=1, six pixels:
  - overflow=1 and frame_words=4;
  - only the first 4 samples are stored.
- FRAME_START mid-frame after 3 pixels, then 2 pixels and FRAME_END: frame_words reflects 2 pixels only (PPW=1, value 2).
- Release (di_read_mode falling) on the same edge as another frame's FRAME_END: count is unchanged and both pointers advance. Separately, asserting resetb=0 mid-read clears all outputs immediately.

Source files
------------

// File: rtl/stream2di_multibuf.sv
// stream2di_multibuf: packs imager stream samples into DI words and captures
// whole frames into a ring of NUM_BUFS buffers, handed to the DI read port in order.
// Read handshake: the host raises di_read_mode to claim the oldest committed
// frame; while di_read_rdy is high, di_reg_datao holds the current word and a
// di_read pulse consumes it; dropping di_read_mode releases the buffer.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 4'h4
`endif

module stream2di_multibuf #(
  parameter int ADDR_WIDTH        = 10,
  parameter int DI_DATA_WIDTH     = 32,
  parameter int STREAM_DATA_WIDTH = 16,
  parameter int NUM_BUFS          = 4,
  parameter int BUF_IDX_WIDTH     = 2
) (
  input  logic                          clki,
  input  logic                          resetb,
  input  logic                          enable,
  input  logic                          dvi,
  input  logic [`DTYPE_WIDTH-1:0]       dtypei,
  input  logic [STREAM_DATA_WIDTH-1:0]  datai0,
  input  logic [STREAM_DATA_WIDTH-1:0]  datai1,
  input  logic [STREAM_DATA_WIDTH-1:0]  datai2,
  input  logic                          mode,
  input  logic                          di_read_mode,
  input  logic                          di_read,
  output logic                          di_read_rdy,
  output logic [DI_DATA_WIDTH-1:0]      di_reg_datao,
  output logic [ADDR_WIDTH:0]           frame_words,
  output logic [15:0]                   frames_dropped,
  output logic                          overflow,
  output logic [1:0]                    wr_state_dbg,
  output logic                          rd_state_dbg
);

  localparam int PPW   = DI_DATA_WIDTH / STREAM_DATA_WIDTH;
  localparam int SW    = STREAM_DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [2:0]             PPW_W    = 3'(PPW);
  localparam logic [ADDR_WIDTH:0]    DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [BUF_IDX_WIDTH:0] FULL_CNT = (BUF_IDX_WIDTH+1)'(NUM_BUFS);

  typedef enum logic [1:0] {WIDLE = 2'd0, WCAPTURE = 2'd1, WDROP = 2'd2} wstate_t;
  typedef enum logic {RIDLE = 1'b0, RREAD = 1'b1} rstate_t;

  wstate_t                    wstate_q, wstate_d;
  rstate_t                    rstate_q, rstate_d;
  logic [BUF_IDX_WIDTH-1:0]   head_q, head_d, tail_q, tail_d, rbuf_q, rbuf_d;
  logic [BUF_IDX_WIDTH:0]     count_q, count_d;
  logic [ADDR_WIDTH:0]        waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DI_DATA_WIDTH-1:0]   pack_q, pack_d;
  logic [2:0]                 pcnt_q, pcnt_d;
  logic                       mode_q, mode_d;
  logic [ADDR_WIDTH:0]        len_q [NUM_BUFS];
  logic [ADDR_WIDTH:0]        len_d [NUM_BUFS];
  logic [15:0]                dropped_q, dropped_d;
  logic                       overflow_q, overflow_d;
  logic [DI_DATA_WIDTH-1:0]   mem_q [NUM_BUFS*DEPTH];

  logic                       wr_en_d   [3];
  logic [ADDR_WIDTH-1:0]      wr_addr_d [3];
  logic [DI_DATA_WIDTH-1:0]   wr_data_d [3];
  logic [SW-1:0]              samp [3];
  logic [DI_DATA_WIDTH-1:0]   pk;
  logic [2:0]                 pc;
  logic [ADDR_WIDTH:0]        wa;
  logic [1:0]                 slot;
  logic                       commit, release_w;
  logic                       is_start, is_end, is_pixel;

  assign is_start = (dtypei == `DTYPE_FRAME_START);
  assign is_end   = (dtypei == `DTYPE_FRAME_END);
  assign is_pixel = ((dtypei & `DTYPE_PIXEL_MASK) != '0);

  // Write side: capture FSM, sample packer and up to three word writes per beat.
  always_comb begin
    wstate_d = wstate_q; head_d = head_q; waddr_d = waddr_q; pack_d = pack_q;
    pcnt_d = pcnt_q; mode_d = mode_q; dropped_d = dropped_q; overflow_d = overflow_q;
    len_d = len_q; commit = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wr_en_d[j] = 1'b0; wr_addr_d[j] = '0; wr_data_d[j] = '0;
    end
    samp[0] = datai0; samp[1] = datai1; samp[2] = datai2;
    pk = pack_q; pc = pcnt_q; wa = waddr_q; slot = '0;
    case (wstate_q)
      WIDLE: if (dvi && is_start) begin
        if (count_q != FULL_CNT) begin
          wstate_d = WCAPTURE; mode_d = mode; waddr_d = '0; pack_d = '0; pcnt_d = '0;
        end else begin
          wstate_d = WDROP;
          if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 1;
        end
      end
      WCAPTURE: if (dvi) begin
        if (is_start) begin
          // Restart the frame in place; the buffer was never committed.
          mode_d = mode; waddr_d = '0; pack_d = '0; pcnt_d = '0;
        end else if (is_end) begin
          if (pcnt_q != '0) begin
            if (wa != DEPTH_W) begin
              wr_en_d[0] = 1'b1; wr_addr_d[0] = wa[ADDR_WIDTH-1:0]; wr_data_d[0] = pk;
              wa = wa + 1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          len_d[head_q] = wa;
          commit = 1'b1;
          head_d = head_q + 1;
          wstate_d = WIDLE;
        end else if (is_pixel) begin
          for (int k = 0; k < 3; k++) begin
            if (k == 0 || mode_q) begin
              pk[pc*SW +: SW] = samp[k];
              pc = pc + 1;
              if (pc == PPW_W) begin
                if (wa != DEPTH_W) begin
                  wr_en_d[slot] = 1'b1; wr_addr_d[slot] = wa[ADDR_WIDTH-1:0];
                  wr_data_d[slot] = pk;
                  wa = wa + 1; slot = slot + 1;
                end else begin
                  overflow_d = 1'b1;
                end
                pk = '0; pc = '0;
              end
            end
          end
          pack_d = pk; pcnt_d = pc; waddr_d = wa;
        end
      end
      WDROP: if (dvi && is_end) wstate_d = WIDLE;
      default: wstate_d = WIDLE;
    endcase
    if (!enable) begin
      wstate_d = WIDLE; head_d = '0; waddr_d = '0; pack_d = '0; pcnt_d = '0;
      mode_d = 1'b0; dropped_d = '0; overflow_d = 1'b0; commit = 1'b0;
      for (int i = 0; i < NUM_BUFS; i++) len_d[i] = '0;
      for (int j = 0; j < 3; j++) wr_en_d[j] = 1'b0;
    end
  end

  // Read side: claim the oldest frame, walk its words, release on mode fall.
  always_comb begin
    rstate_d = rstate_q; rbuf_d = rbuf_q; raddr_d = raddr_q; tail_d = tail_q;
    release_w = 1'b0;
    di_read_rdy = (rstate_q == RREAD) && (raddr_q < len_q[rbuf_q]);
    case (rstate_q)
      RIDLE: if (di_read_mode && count_q != '0) begin
        rstate_d = RREAD; rbuf_d = tail_q; raddr_d = '0;
      end
      RREAD: begin
        if (!di_read_mode) begin
          release_w = 1'b1; tail_d = tail_q + 1; rstate_d = RIDLE;
        end else if (di_read && di_read_rdy) begin
          raddr_d = raddr_q + 1;
        end
      end
      default: rstate_d = RIDLE;
    endcase
    if (!enable) begin
      rstate_d = RIDLE; rbuf_d = '0; raddr_d = '0; tail_d = '0; release_w = 1'b0;
    end
  end

  // Occupancy: commit and release in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (commit && !release_w) count_d = count_q + 1;
    else if (!commit && release_w) count_d = count_q - 1;
    if (!enable) count_d = '0;
  end

  // State registers.
  always_ff @(posedge clki or negedge resetb) begin
    if (!resetb) begin
      wstate_q <= WIDLE; rstate_q <= RIDLE;
      head_q <= '0; tail_q <= '0; rbuf_q <= '0; count_q <= '0;
      waddr_q <= '0; raddr_q <= '0; pack_q <= '0; pcnt_q <= '0; mode_q <= 1'b0;
      dropped_q <= '0; overflow_q <= 1'b0;
      for (int i = 0; i < NUM_BUFS; i++) len_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d; rstate_q <= rstate_d;
      head_q <= head_d; tail_q <= tail_d; rbuf_q <= rbuf_d; count_q <= count_d;
      waddr_q <= waddr_d; raddr_q <= raddr_d; pack_q <= pack_d; pcnt_q <= pcnt_d;
      mode_q <= mode_d; dropped_q <= dropped_d; overflow_q <= overflow_d;
      for (int i = 0; i < NUM_BUFS; i++) len_q[i] <= len_d[i];
    end
  end

  // Frame storage; the buffer under capture is always the head buffer.
  always_ff @(posedge clki) begin
    for (int j = 0; j < 3; j++) begin
      if (wr_en_d[j]) mem_q[{head_q, wr_addr_d[j]}] <= wr_data_d[j];
    end
  end

  assign di_reg_datao   = di_read_rdy ? mem_q[{rbuf_q, raddr_q[ADDR_WIDTH-1:0]}] : '0;
  assign frame_words    = (count_q != '0) ? len_q[tail_q] : '0;
  assign frames_dropped = dropped_q;
  assign overflow       = overflow_q;
  assign wr_state_dbg   = wstate_q;
  assign rd_state_dbg   = rstate_q;

endmodule

// File: tb/tb_stream2di_multibuf.sv
// Bench for stream2di_multibuf: instance A packs two samples per word,
// instance B stores one sample per word in 4-word buffers.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 4'h4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'h4
`endif

module tb_stream2di_multibuf;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb, enable, dvi, mode, di_read_mode, di_read;
  logic [`DTYPE_WIDTH-1:0] dtypei;
  logic [15:0] datai0, datai1, datai2;

  logic        a_rdy, b_rdy;
  logic [31:0] a_data;
  logic [15:0] b_data;
  logic [4:0]  a_fw;
  logic [2:0]  b_fw;
  logic [15:0] a_drop, b_drop;
  logic        a_ovf, b_ovf;
  logic [1:0]  a_ws, b_ws;
  logic        a_rs, b_rs;

  stream2di_multibuf #(.ADDR_WIDTH(4), .DI_DATA_WIDTH(32), .STREAM_DATA_WIDTH(16),
                       .NUM_BUFS(4), .BUF_IDX_WIDTH(2)) u_a (
    .clki(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .datai0(datai0), .datai1(datai1), .datai2(datai2), .mode(mode),
    .di_read_mode(di_read_mode), .di_read(di_read), .di_read_rdy(a_rdy),
    .di_reg_datao(a_data), .frame_words(a_fw), .frames_dropped(a_drop),
    .overflow(a_ovf), .wr_state_dbg(a_ws), .rd_state_dbg(a_rs));

  stream2di_multibuf #(.ADDR_WIDTH(2), .DI_DATA_WIDTH(16), .STREAM_DATA_WIDTH(16),
                       .NUM_BUFS(4), .BUF_IDX_WIDTH(2)) u_b (
    .clki(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .datai0(datai0), .datai1(datai1), .datai2(datai2), .mode(mode),
    .di_read_mode(di_read_mode), .di_read(di_read), .di_read_rdy(b_rdy),
    .di_reg_datao(b_data), .frame_words(b_fw), .frames_dropped(b_drop),
    .overflow(b_ovf), .wr_state_dbg(b_ws), .rd_state_dbg(b_rs));

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] smp [0:63];
  logic [31:0] exp_w;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0; enable = 1'b1; dvi = 1'b0; dtypei = '0; mode = 1'b0;
    datai0 = '0; datai1 = '0; datai2 = '0; di_read_mode = 1'b0; di_read = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    tick();
  endtask

  task automatic beat(input logic [`DTYPE_WIDTH-1:0] dt, input logic [15:0] d0,
                      input logic [15:0] d1, input logic [15:0] d2);
    dvi = 1'b1; dtypei = dt; datai0 = d0; datai1 = d1; datai2 = d2;
    tick();
  endtask

  task automatic bus_idle();
    dvi = 1'b0; dtypei = '0; datai0 = '0; datai1 = '0; datai2 = '0;
  endtask

  // Sends one frame built from smp[]; mode 1 takes samples three per pixel.
  task automatic send_frame(input int npix, input logic md);
    mode = md;
    beat(`DTYPE_FRAME_START, 16'h0, 16'h0, 16'h0);
    for (int p = 0; p < npix; p++) begin
      if (md) beat(`DTYPE_PIXEL, smp[3*p], smp[3*p+1], smp[3*p+2]);
      else    beat(`DTYPE_PIXEL, smp[p], 16'h0, 16'h0);
    end
    beat(`DTYPE_FRAME_END, 16'h0, 16'h0, 16'h0);
    bus_idle();
  endtask

  // Reference packing for A: flat sample list, two per word, LSB first.
  task automatic model_push_a(input int ns);
    for (int i = 0; i < ns; i += 2)
      exp_q.push_back({(i + 1 < ns) ? smp[i+1] : 16'h0, smp[i]});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (a_rdy !== 1'b0) $display("FAIL reset_rdy got %0b exp 0", a_rdy); else n_pass++;
    n_checks++; if (a_data !== 32'h0) $display("FAIL reset_data got %0h exp 0", a_data); else n_pass++;
    n_checks++; if (a_fw !== 5'd0) $display("FAIL reset_fw got %0d exp 0", a_fw); else n_pass++;
    n_checks++; if (a_drop !== 16'd0) $display("FAIL reset_drop got %0d exp 0", a_drop); else n_pass++;
    n_checks++; if (a_ovf !== 1'b0) $display("FAIL reset_ovf got %0b exp 0", a_ovf); else n_pass++;
    n_checks++; if ({a_ws, a_rs} !== 3'b000) $display("FAIL reset_fsm got %0h exp 0", {a_ws, a_rs}); else n_pass++;
    n_checks++; if (b_fw !== 3'd0) $display("FAIL reset_b_fw got %0d exp 0", b_fw); else n_pass++;
  endtask

  task automatic test_mode0();
    do_reset();
    for (int i = 0; i < 5; i++) smp[i] = 16'(i + 1);
    send_frame(5, 1'b0);
    exp_q.push_back(32'h00020001); exp_q.push_back(32'h00040003); exp_q.push_back(32'h00000005);
    n_checks++; if (a_fw !== 5'd3) $display("FAIL m0_fw got %0d exp 3", a_fw); else n_pass++;
    di_read_mode = 1'b1; tick();
    n_checks++; if (a_rdy !== 1'b1) $display("FAIL m0_rdy_start got %0b exp 1", a_rdy); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      exp_w = exp_q.pop_front();
      n_checks++; if (a_data !== exp_w) $display("FAIL m0_word%0d got %0h exp %0h", k, a_data, exp_w); else n_pass++;
      di_read = 1'b1; tick();
    end
    di_read = 1'b0;
    n_checks++; if (a_rdy !== 1'b0) $display("FAIL m0_rdy_end got %0b exp 0", a_rdy); else n_pass++;
    n_checks++; if (a_data !== 32'h0) $display("FAIL m0_data_end got %0h exp 0", a_data); else n_pass++;
    di_read_mode = 1'b0; tick();
    n_checks++; if (a_fw !== 5'd0) $display("FAIL m0_fw_released got %0d exp 0", a_fw); else n_pass++;
  endtask

  task automatic test_mode1();
    do_reset();
    for (int i = 0; i < 6; i++) smp[i] = 16'(i + 1);
    send_frame(2, 1'b1);
    exp_q.push_back(32'h00020001); exp_q.push_back(32'h00040003); exp_q.push_back(32'h00060005);
    n_checks++; if (a_fw !== 5'd3) $display("FAIL m1_fw got %0d exp 3", a_fw); else n_pass++;
    di_read_mode = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      exp_w = exp_q.pop_front();
      n_checks++; if (a_data !== exp_w) $display("FAIL m1_word%0d got %0h exp %0h", k, a_data, exp_w); else n_pass++;
      di_read = 1'b1; tick();
    end
    di_read = 1'b0; di_read_mode = 1'b0; tick();
  endtask

  task automatic test_drop();
    int ns_tab [5];
    int len_exp [4];
    ns_tab = '{3, 4, 0, 5, 2};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < ns_tab[f]; i++) smp[i] = 16'($urandom_range(0, 16'hFFFF));
      send_frame(ns_tab[f], 1'b0);
      if (f < 4) begin
        model_push_a(ns_tab[f]);
        len_exp[f] = (ns_tab[f] + 1) / 2;
      end
    end
    n_checks++; if (a_drop !== 16'd1) $display("FAIL drop_count got %0d exp 1", a_drop); else n_pass++;
    n_checks++; if (a_ws !== 2'd0) $display("FAIL drop_wstate got %0d exp 0", a_ws); else n_pass++;
    for (int f = 0; f < 4; f++) begin
      n_checks++; if (a_fw !== 5'(len_exp[f])) $display("FAIL drop_fw%0d got %0d exp %0d", f, a_fw, len_exp[f]); else n_pass++;
      di_read_mode = 1'b1; tick();
      n_checks++; if (a_rdy !== (len_exp[f] != 0)) $display("FAIL drop_rdy%0d got %0b exp %0b", f, a_rdy, len_exp[f] != 0); else n_pass++;
      for (int k = 0; k < len_exp[f]; k++) begin
        exp_w = exp_q.pop_front();
        n_checks++; if (a_data !== exp_w) $display("FAIL drop_f%0d_w%0d got %0h exp %0h", f, k, a_data, exp_w); else n_pass++;
        di_read = 1'b1; tick();
      end
      di_read = 1'b0;
      n_checks++; if (a_rdy !== 1'b0) $display("FAIL drop_rdy_end%0d got %0b exp 0", f, a_rdy); else n_pass++;
      di_read_mode = 1'b0; tick();
    end
    n_checks++; if (a_fw !== 5'd0) $display("FAIL drop_empty got %0d exp 0", a_fw); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) smp[i] = 16'(16'h11 + i);
    send_frame(6, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h0, smp[i]});
    n_checks++; if (b_ovf !== 1'b1) $display("FAIL ovf_set got %0b exp 1", b_ovf); else n_pass++;
    n_checks++; if (b_fw !== 3'd4) $display("FAIL ovf_fw got %0d exp 4", b_fw); else n_pass++;
    n_checks++; if (a_ovf !== 1'b0) $display("FAIL ovf_a_clear got %0b exp 0", a_ovf); else n_pass++;
    di_read_mode = 1'b1; tick();
    for (int k = 0; k < 4; k++) begin
      exp_w = exp_q.pop_front();
      n_checks++; if ({16'h0, b_data} !== exp_w) $display("FAIL ovf_word%0d got %0h exp %0h", k, b_data, exp_w); else n_pass++;
      di_read = 1'b1; tick();
    end
    di_read = 1'b0;
    n_checks++; if (b_rdy !== 1'b0) $display("FAIL ovf_rdy_end got %0b exp 0", b_rdy); else n_pass++;
    di_read_mode = 1'b0; tick();
    n_checks++; if (b_ovf !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", b_ovf); else n_pass++;
  endtask

  task automatic test_abort();
    do_reset();
    mode = 1'b0;
    beat(`DTYPE_FRAME_START, 16'h0, 16'h0, 16'h0);
    beat(`DTYPE_PIXEL, 16'hA1, 16'h0, 16'h0);
    beat(`DTYPE_PIXEL, 16'hA2, 16'h0, 16'h0);
    beat(`DTYPE_PIXEL, 16'hA3, 16'h0, 16'h0);
    beat(`DTYPE_FRAME_START, 16'h0, 16'h0, 16'h0);
    beat(`DTYPE_PIXEL, 16'hB1, 16'h0, 16'h0);
    beat(`DTYPE_PIXEL, 16'hB2, 16'h0, 16'h0);
    beat(`DTYPE_FRAME_END, 16'h0, 16'h0, 16'h0);
    bus_idle();
    exp_q.push_back(32'h00B1); exp_q.push_back(32'h00B2);
    n_checks++; if (b_fw !== 3'd2) $display("FAIL abort_b_fw got %0d exp 2", b_fw); else n_pass++;
    n_checks++; if (a_fw !== 5'd1) $display("FAIL abort_a_fw got %0d exp 1", a_fw); else n_pass++;
    di_read_mode = 1'b1; tick();
    n_checks++; if (a_data !== 32'h00B200B1) $display("FAIL abort_a_word got %0h exp 00b200b1", a_data); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      exp_w = exp_q.pop_front();
      n_checks++; if ({16'h0, b_data} !== exp_w) $display("FAIL abort_b_word%0d got %0h exp %0h", k, b_data, exp_w); else n_pass++;
      di_read = 1'b1; tick();
    end
    di_read = 1'b0; di_read_mode = 1'b0; tick();
  endtask

  task automatic test_commit_release();
    do_reset();
    for (int i = 0; i < 4; i++) smp[i] = 16'(16'h10 + i);
    send_frame(4, 1'b0);
    di_read_mode = 1'b1; tick();
    n_checks++; if (a_fw !== 5'd2) $display("FAIL cr_fw_x got %0d exp 2", a_fw); else n_pass++;
    beat(`DTYPE_FRAME_START, 16'h0, 16'h0, 16'h0);
    beat(`DTYPE_PIXEL, 16'h21, 16'h0, 16'h0);
    beat(`DTYPE_PIXEL, 16'h22, 16'h0, 16'h0);
    di_read_mode = 1'b0;
    beat(`DTYPE_FRAME_END, 16'h0, 16'h0, 16'h0);
    bus_idle();
    n_checks++; if (a_fw !== 5'd1) $display("FAIL cr_fw_y got %0d exp 1", a_fw); else n_pass++;
    n_checks++; if (b_fw !== 3'd2) $display("FAIL cr_b_fw_y got %0d exp 2", b_fw); else n_pass++;
    n_checks++; if ({a_ws, a_rs} !== 3'b000) $display("FAIL cr_fsm got %0h exp 0", {a_ws, a_rs}); else n_pass++;
    di_read_mode = 1'b1; tick();
    n_checks++; if (a_data !== 32'h00220021) $display("FAIL cr_word got %0h exp 00220021", a_data); else n_pass++;
    di_read_mode = 1'b0; tick();
    n_checks++; if (a_fw !== 5'd0) $display("FAIL cr_empty got %0d exp 0", a_fw); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int i = 0; i < 4; i++) smp[i] = 16'(16'h30 + i);
    send_frame(4, 1'b0);
    di_read_mode = 1'b1; tick();
    n_checks++; if (a_data !== 32'h00310030) $display("FAIL rmr_word got %0h exp 00310030", a_data); else n_pass++;
    #2 resetb = 1'b0;
    #1;
    n_checks++; if (a_rdy !== 1'b0) $display("FAIL rmr_rdy got %0b exp 0", a_rdy); else n_pass++;
    n_checks++; if (a_data !== 32'h0) $display("FAIL rmr_data got %0h exp 0", a_data); else n_pass++;
    n_checks++; if (a_fw !== 5'd0) $display("FAIL rmr_fw got %0d exp 0", a_fw); else n_pass++;
    di_read_mode = 1'b0;
    tick();
    resetb = 1'b1;
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < 6; i++) smp[i] = 16'(16'h40 + i);
    send_frame(6, 1'b0);
    n_checks++; if (b_ovf !== 1'b1) $display("FAIL en_pre_ovf got %0b exp 1", b_ovf); else n_pass++;
    enable = 1'b0; tick();
    n_checks++; if (a_fw !== 5'd0) $display("FAIL en_fw got %0d exp 0", a_fw); else n_pass++;
    n_checks++; if (b_ovf !== 1'b0) $display("FAIL en_ovf got %0b exp 0", b_ovf); else n_pass++;
    enable = 1'b1; tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_drop();
    test_overflow();
    test_abort();
    test_commit_release();
    test_reset_mid_read();
    test_enable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
